// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU with built-in ALU-control decode and iterative MULT/DIV into HI/LO.
// Single-cycle ops complete the cycle after accept; mul/div stall the pipeline via Ready.
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  input  logic [1:0]       ALUOP,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Illegal
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
  } op_e;

  state_e             state_q, state_d;
  op_e                op;
  logic               accept, is_muldiv, is_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, alu_res;
  logic [WIDTH-1:0]   hi_q, lo_q, b_mag_q, result_q;
  logic [2*WIDTH-1:0] p_q, mul_step, div_step, prod_fix;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, neg_q, neg_rem_q, div0_q, done_q, zero_q, illegal_q;
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_new, fix_hi, fix_lo;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    op = OP_ILL;
    if (ALUOP == 2'b00)      op = OP_ADD;
    else if (ALUOP == 2'b01) op = OP_SUB;
    else begin
      unique case (Func)
        6'b100000: op = OP_ADD;
        6'b100010: op = OP_SUB;
        6'b100100: op = OP_AND;
        6'b100101: op = OP_OR;
        6'b101010: op = OP_SLT;
        6'b101011: op = OP_SLTU;
        6'b010000: op = OP_MFHI;
        6'b010010: op = OP_MFLO;
        6'b011000: op = OP_MULT;
        6'b011001: op = OP_MULTU;
        6'b011010: op = OP_DIV;
        6'b011011: op = OP_DIVU;
        default:   op = OP_ILL;
      endcase
    end
  end

  assign accept    = InValid && Ready;
  assign is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed && A[WIDTH-1];
  assign b_neg     = op_signed && B[WIDTH-1];
  // Two's-complement negation maps -2^(WIDTH-1) onto the unsigned magnitude 2^(WIDTH-1).
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_mag_q} : '0);
  assign mul_step = {mul_sum, p_q[WIDTH-1:1]};
  assign rem_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, b_mag_q};
  assign div_diff = rem_sh - {1'b0, b_mag_q};
  assign rem_new  = div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_step = {rem_new, p_q[WIDTH-2:0], div_ge};
  assign prod_fix = neg_q ? -p_q : p_q;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (div0_q) begin
      fix_hi = p_q[WIDTH-1:0];
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_hi = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
      fix_lo = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && is_muldiv) state_d = (is_div && B == '0) ? S_FIX : S_RUN;
      S_RUN:   if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Ready = (state_q == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      b_mag_q   <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (accept && is_muldiv) begin
      p_q       <= {{WIDTH{1'b0}}, (is_div && B == '0) ? A : a_mag};
      b_mag_q   <= b_mag;
      cnt_q     <= CNT_W'(WIDTH);
      is_div_q  <= is_div;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      div0_q    <= is_div && (B == '0);
    end else if (state_q == S_RUN) begin
      p_q   <= is_div_q ? div_step : mul_step;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (state_q == S_FIX) begin
      hi_q      <= fix_hi;
      lo_q      <= fix_lo;
      result_q  <= fix_lo;
      zero_q    <= (fix_lo == '0);
      illegal_q <= 1'b0;
      done_q    <= 1'b1;
    end else if (accept && !is_muldiv) begin
      result_q  <= alu_res;
      zero_q    <= (alu_res == '0);
      illegal_q <= (op == OP_ILL);
      done_q    <= 1'b1;
    end else begin
      done_q    <= 1'b0;
    end
  end

  assign Done    = done_q;
  assign Result  = result_q;
  assign Zero    = zero_q;
  assign Illegal = illegal_q;

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Next-generation execute-stage ALU for the MIPS core, with ALU-control decode built in.
- Decodes ALUOP/Func, performs single-cycle ops, and runs iterative MULT/MULTU/DIV/DIVU into internal HI/LO registers.
- Provides a ready/valid/done handshake so the pipeline control stalls while a multiply or divide is in progress.

Parameters:
- WIDTH, 32, datapath width in bits (≥4). HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  operation request; accepted on a rising edge where InValid && Ready.
- ALUOP  in  2  00=ADD, 01=SUB, 1x=R-type (decode Func).
- Func  in  6  R-type function field.
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt.
- Ready  out  1  high only in IDLE.
- Done  out  1  one-cycle pulse when Result/HI/LO are valid.
- Result  out  WIDTH  registered result; holds until the next Done.
- Zero  out  1  registered (Result==0), updated with Result.
- Illegal  out  1  registered; set with Done for an undecoded Func.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, Ready=1, Done=0, Result=0, Zero=1, Illegal=0, HI=0, LO=0, counter=0. Reset mid-operation aborts the op; HI/LO are cleared.
- Decode, ALUOP=00: ADD. ALUOP=01: SUB. ALUOP=1x, by Func:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed), 101011 SLTU.
  - 010000 MFHI, 010010 MFLO.
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - Any other Func: Illegal.
- ADD/SUB: modulo 2^WIDTH; no overflow trap.
- SLT/SLTU: Result is 1 or 0, zero-extended to WIDTH.
- Single-cycle ops (ALU ops, MFHI, MFLO, Illegal):
  - On the accept edge, Result/Zero/Illegal are registered and Done=1 in the following cycle.
  - Ready stays 1, so back-to-back accepts give one Done per cycle.
  - Illegal: Result=0, Zero=1, Illegal=1.
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on accepting a mul/div op. The unit latches operand magnitudes (absolute values for signed ops; -2^(WIDTH-1) maps to 2^(WIDTH-1)), the result signs, the op kind, and sets counter=WIDTH.
  - RUN: one iteration per cycle; counter decrements; RUN→FIX when counter reaches 1.
  - Multiply iteration: shift-add, 2*WIDTH-bit product.
  - Divide iteration: restoring shift-subtract, giving quotient and remainder.
  - FIX, one cycle:
    - Signed MULT: negate the 2*WIDTH product if sign(A)^sign(B).
    - Signed DIV: quotient negative iff sign(A)^sign(B); remainder takes sign(A).
    - Write HI/LO: MULT gives HI=upper, LO=lower; DIV gives HI=remainder, LO=quotient.
    - FIX→IDLE.
  - Done pulses in the cycle after FIX. Result=LO, Zero=(LO==0), Illegal=0.
- Mul/div latency: Done is high WIDTH+2 cycles after the accept edge. Ready is 0 from the cycle after accept until FIX→IDLE.
- Divide by zero: no trap; HI=A (unmodified dividend), LO=all ones. Divisor==0 is detected at accept and the iterations are skipped: IDLE→FIX directly, Done at accept+2.
- DIV with -2^(WIDTH-1) / -1: LO=-2^(WIDTH-1) (wrap), HI=0.
- InValid while Ready=0 is ignored; the requester must hold the request.
- MFHI/MFLO cannot overlap a mul/div (interlock via Ready) and always return the completed values.
- Operands are sampled only at accept; later changes to A/B/Func are ignored.

Test Plan (all cases WIDTH=32):
- Reset, then ALUOP=10, Func=101010, A=0xFFFFFFFF, B=1 → next cycle Done=1, Result=1. Repeat with Func=101011 → Result=0.
- MULT A=-3, B=7 → Ready low; Done exactly 34 cycles after accept; then MFHI gives 0xFFFFFFFF and MFLO gives 0xFFFFFFEB (-21).
- DIV A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 → LO=3, HI=1.
- DIVU A=5, B=0 → Done at accept+2; HI=5, LO=0xFFFFFFFF.
- InValid held with ADD during a MULTU → no Done until MULTU completes; ADD accepted the cycle Ready rises, Done the cycle after. Back-to-back ADD/SUB/AND give three consecutive Done pulses.
- rst_n low mid-DIV → Ready=1, Done=0, HI=LO=0 immediately; Func=111111 after reset → Illegal=1, Result=0, Zero=1.
